kv_reply_tx: RTL

Transmit-side frame builder for the key-value datapath. It accepts one lookup result per request: key, value, flag and the requester's addressing. It serialises a fixed 62-byte Ethernet/IPv4/UDP reply frame onto the 64-bit AXI-Stream TX interface of a 10G MAC port. It sits between the key-value lookup logic and the MAC TX stream, in the 156.25 MHz Ethernet clock domain.

---
 rtl/kv_reply_tx.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/kv_reply_tx.sv
`default_nettype none
// ============================================================================
// Module      : kv_reply_tx
// Description : Builds and serialises a 62-byte Ethernet/IPv4/UDP reply frame
//               per key-value lookup result onto a 64-bit AXI-Stream TX port.
//               Optional macro KV_REPLY_IPCSUM_EN enables the IPv4 header
//               checksum (extra CSUM cycle); otherwise the checksum is 0x0000.
// Revision    : 1.0 - initial release
// ============================================================================
module kv_reply_tx #(
    parameter int          KEY_SIZE = 96,
    parameter int          VAL_SIZE = 32,
    parameter logic [47:0] SRC_MAC  = 48'h00_0A_35_00_00_01,
    parameter logic [31:0] SRC_IP   = 32'h0A_00_00_01,
    parameter logic [15:0] SRC_PORT = 16'd11211
) (
    input  logic                clk156,
    input  logic                eth_rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_SIZE-1:0] req_key,
    input  logic [VAL_SIZE-1:0] req_val,
    input  logic [3:0]          req_flag,
    input  logic [47:0]         req_dst_mac,
    input  logic [31:0]         req_dst_ip,
    input  logic [15:0]         req_dst_port,
    output logic                m_axis_tx_tvalid,
    input  logic                m_axis_tx_tready,
    output logic [63:0]         m_axis_tx_tdata,
    output logic [7:0]          m_axis_tx_tkeep,
    output logic                m_axis_tx_tlast,
    output logic                m_axis_tx_tuser,
    output logic [31:0]         tx_frames
);

`ifdef KV_REPLY_IPCSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CSUM = 2'd1,
        ST_SEND = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd2
    } state_t;
`endif

    state_t                r_state;
    logic [2:0]            r_beat;
    logic [KEY_SIZE-1:0]   r_key;
    logic [VAL_SIZE-1:0]   r_val;
    logic [3:0]            r_flag;
    logic [47:0]           r_dst_mac;
    logic [31:0]           r_dst_ip;
    logic [15:0]           r_dst_port;
    logic [15:0]           r_ident;

    logic [15:0]           w_csum_field;
    logic [47:0]           w_mac_src;
    logic [2:0]            w_next_idx;
    logic [511:0]          w_hdr;
    logic [511:0]          w_shifted;
    logic [63:0]           w_beat_data;

`ifdef KV_REPLY_IPCSUM_EN
    logic [15:0]           r_csum;
    logic [31:0]           w_sum;
    logic [16:0]           w_fold1;
    logic [15:0]           w_fold2;

    assign w_sum = 32'h0000_4500 + 32'h0000_0030 + {16'h0000, r_ident}
                 + 32'h0000_4000 + 32'h0000_4011
                 + {16'h0000, SRC_IP[31:16]}   + {16'h0000, SRC_IP[15:0]}
                 + {16'h0000, r_dst_ip[31:16]} + {16'h0000, r_dst_ip[15:0]};
    assign w_fold1      = {1'b0, w_sum[15:0]} + {1'b0, w_sum[31:16]};
    assign w_fold2      = w_fold1[15:0] + {15'h0000, w_fold1[16]};
    assign w_csum_field = r_csum;
`else
    assign w_csum_field = 16'h0000;
`endif

    // Beat 0 is loaded on the capture edge in the no-checksum build, so the
    // MAC must come straight from the request port while idle.
    assign w_mac_src  = (r_state == ST_IDLE) ? req_dst_mac : r_dst_mac;
    assign w_next_idx = (r_state == ST_SEND) ? (r_beat + 3'd1) : 3'd0;

    // Whole frame in wire order, byte 0 at the MSB end, padded to 64 bytes.
    assign w_hdr = {w_mac_src, SRC_MAC, 16'h0800,
                    8'h45, 8'h00, 16'h0030, r_ident,
                    16'h4000, 8'h40, 8'h11, w_csum_field,
                    SRC_IP, r_dst_ip,
                    SRC_PORT, r_dst_port, 16'h001C, 16'h0000,
                    4'h0, r_flag, 24'h000000,
                    r_key, r_val, 16'h0000};

    assign w_shifted = w_hdr << {w_next_idx, 6'b000000};

    always_comb begin
        w_beat_data = {<<8{w_shifted[511:448]}};
    end

    assign m_axis_tx_tuser = 1'b0;

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            r_state          <= ST_IDLE;
            r_beat           <= 3'd0;
            r_key            <= '0;
            r_val            <= '0;
            r_flag           <= 4'h0;
            r_dst_mac        <= 48'h0;
            r_dst_ip         <= 32'h0;
            r_dst_port       <= 16'h0;
            r_ident          <= 16'h0;
`ifdef KV_REPLY_IPCSUM_EN
            r_csum           <= 16'h0;
`endif
            req_ready        <= 1'b0;
            m_axis_tx_tvalid <= 1'b0;
            m_axis_tx_tdata  <= 64'h0;
            m_axis_tx_tkeep  <= 8'h00;
            m_axis_tx_tlast  <= 1'b0;
            tx_frames        <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_key      <= req_key;
                        r_val      <= req_val;
                        r_flag     <= req_flag;
                        r_dst_mac  <= req_dst_mac;
                        r_dst_ip   <= req_dst_ip;
                        r_dst_port <= req_dst_port;
                        req_ready  <= 1'b0;
`ifdef KV_REPLY_IPCSUM_EN
                        r_state    <= ST_CSUM;
`else
                        r_state          <= ST_SEND;
                        r_beat           <= 3'd0;
                        m_axis_tx_tvalid <= 1'b1;
                        m_axis_tx_tdata  <= w_beat_data;
                        m_axis_tx_tkeep  <= 8'hFF;
                        m_axis_tx_tlast  <= 1'b0;
`endif
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
`ifdef KV_REPLY_IPCSUM_EN
                ST_CSUM: begin
                    r_csum           <= ~w_fold2;
                    r_state          <= ST_SEND;
                    r_beat           <= 3'd0;
                    m_axis_tx_tvalid <= 1'b1;
                    m_axis_tx_tdata  <= w_beat_data;
                    m_axis_tx_tkeep  <= 8'hFF;
                    m_axis_tx_tlast  <= 1'b0;
                end
`endif
                ST_SEND: begin
                    if (m_axis_tx_tvalid && m_axis_tx_tready) begin
                        if (r_beat == 3'd7) begin
                            m_axis_tx_tvalid <= 1'b0;
                            m_axis_tx_tdata  <= 64'h0;
                            m_axis_tx_tkeep  <= 8'h00;
                            m_axis_tx_tlast  <= 1'b0;
                            r_state          <= ST_IDLE;
                            req_ready        <= 1'b1;
                            r_ident          <= r_ident + 16'd1;
                            tx_frames        <= tx_frames + 32'd1;
                        end else begin
                            r_beat           <= w_next_idx;
                            m_axis_tx_tdata  <= w_beat_data;
                            m_axis_tx_tkeep  <= (w_next_idx == 3'd7) ? 8'h3F : 8'hFF;
                            m_axis_tx_tlast  <= (w_next_idx == 3'd7);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
